// File: rtl/uart_pkg.sv
// Shared definitions for the UART loopback buffer: mode encodings, transmit FSM states
// and a saturating counter helper.
package uart_pkg;

    localparam logic [1:0] MODE_STREAM = 2'd0;
    localparam logic [1:0] MODE_LINE   = 2'd1;
    localparam logic [1:0] MODE_PAUSE  = 2'd2;
    localparam logic [1:0] MODE_FLUSH  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_POP       = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } tx_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, registered level/full/empty/almost-full
// flags and a synchronous clear that empties it.
module sync_fifo #(
    parameter int P_WIDTH = 8,
    parameter int P_DEPTH = 64,
    parameter int P_AFULL = 48,
    localparam int AW = $clog2(P_DEPTH),
    localparam int LW = AW + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               wr_en,
    input  logic [P_WIDTH-1:0] wr_data,
    input  logic               rd_en,
    output logic [P_WIDTH-1:0] rd_data,
    output logic [LW-1:0]      level,
    output logic               full,
    output logic               empty,
    output logic               afull
);

    logic [P_WIDTH-1:0] mem_r [P_DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [LW-1:0]      level_r;
    logic [LW-1:0]      level_next_s;
    logic               full_r;
    logic               empty_r;
    logic               afull_r;
    logic [P_WIDTH-1:0] rd_data_r;
    logic               wr_do_s;
    logic               rd_do_s;

    // Full/empty are the registered flags, so a pop cannot make room for a same-cycle write.
    assign wr_do_s = wr_en && !full_r && !clr;
    assign rd_do_s = rd_en && !empty_r && !clr;

    // Next occupancy from the accepted write/read pair.
    always_comb begin
        level_next_s = level_r;
        if (clr) begin
            level_next_s = {LW{1'b0}};
        end else begin
            case ({wr_do_s, rd_do_s})
                2'b10:   level_next_s = level_r + LW'(1);
                2'b01:   level_next_s = level_r - LW'(1);
                default: level_next_s = level_r;
            endcase
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (wr_do_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, status flags and registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            level_r   <= {LW{1'b0}};
            full_r    <= 1'b0;
            empty_r   <= 1'b1;
            afull_r   <= 1'b0;
            rd_data_r <= {P_WIDTH{1'b0}};
        end else begin
            if (clr) begin
                wr_ptr_r <= {AW{1'b0}};
                rd_ptr_r <= {AW{1'b0}};
            end else begin
                if (wr_do_s) begin
                    wr_ptr_r <= wr_ptr_r + AW'(1);
                end
                if (rd_do_s) begin
                    rd_ptr_r  <= rd_ptr_r + AW'(1);
                    rd_data_r <= mem_r[rd_ptr_r];
                end
            end
            level_r <= level_next_s;
            full_r  <= (level_next_s == LW'(P_DEPTH));
            empty_r <= (level_next_s == {LW{1'b0}});
            afull_r <= (level_next_s >= LW'(P_AFULL));
        end
    end

    assign rd_data = rd_data_r;
    assign level   = level_r;
    assign full    = full_r;
    assign empty   = empty_r;
    assign afull   = afull_r;

endmodule

// File: rtl/uart_loopback_buffer.sv
// Receive-to-transmit loopback buffer: FIFO plus mode-dependent send control, line
// counting, RTS flow control and drop statistics.
module uart_loopback_buffer
    import uart_pkg::*;
#(
    parameter int                    P_DATA_WIDTH = 8,
    parameter int                    P_DEPTH      = 64,
    parameter int                    P_AFULL      = 48,
    parameter logic [P_DATA_WIDTH-1:0] P_EOL      = 8'h0A,
    localparam int                   LW           = $clog2(P_DEPTH) + 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [P_DATA_WIDTH-1:0] i_rx_data,
    input  logic                    i_rx_valid,
    output logic [P_DATA_WIDTH-1:0] o_tx_data,
    output logic                    o_tx_valid,
    input  logic                    i_tx_ready,
    input  logic [1:0]              i_mode,
    input  logic                    i_clr_stat,
    output logic [LW-1:0]           o_level,
    output logic                    o_full,
    output logic                    o_empty,
    output logic                    o_rts_n,
    output logic                    o_overflow,
    output logic [7:0]              o_drop_cnt
);

    tx_state_e               state_r;
    tx_state_e               next_state_s;
    logic                    tx_valid_r;
    logic [LW-1:0]           line_cnt_r;
    logic                    overflow_r;
    logic [7:0]              drop_cnt_r;
    logic [P_DATA_WIDTH-1:0] rd_data_s;
    logic [LW-1:0]           level_s;
    logic                    full_s;
    logic                    empty_s;
    logic                    afull_s;
    logic                    wr_try_s;
    logic                    wr_ok_s;
    logic                    drop_s;
    logic                    flush_clr_s;
    logic                    rd_en_s;
    logic                    go_s;
    logic                    line_inc_s;
    logic                    line_dec_s;

    assign wr_try_s    = i_rx_valid && (i_mode != MODE_FLUSH);
    assign wr_ok_s     = wr_try_s && !full_s;
    assign drop_s      = wr_try_s && full_s;
    // Flush waits for IDLE so a byte already being sent is never cut short.
    assign flush_clr_s = (state_r == ST_IDLE) && (i_mode == MODE_FLUSH);
    assign rd_en_s     = (state_r == ST_POP);
    assign line_inc_s  = wr_ok_s && (i_rx_data == P_EOL);
    assign line_dec_s  = (state_r == ST_SEND) && (rd_data_s == P_EOL);

    sync_fifo #(
        .P_WIDTH (P_DATA_WIDTH),
        .P_DEPTH (P_DEPTH),
        .P_AFULL (P_AFULL)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .clr     (flush_clr_s),
        .wr_en   (wr_ok_s),
        .wr_data (i_rx_data),
        .rd_en   (rd_en_s),
        .rd_data (rd_data_s),
        .level   (level_s),
        .full    (full_s),
        .empty   (empty_s),
        .afull   (afull_s)
    );

    // Send permission per mode; a full FIFO in line mode is released to avoid deadlock.
    always_comb begin
        go_s = 1'b0;
        case (i_mode)
            MODE_STREAM: go_s = !empty_s;
            MODE_LINE:   go_s = !empty_s && ((line_cnt_r != {LW{1'b0}}) || full_s);
            default:     go_s = 1'b0;
        endcase
    end

    // Transmit FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (go_s && i_tx_ready) begin
                    next_state_s = ST_POP;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_POP:  next_state_s = ST_SEND;
            ST_SEND: next_state_s = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (!i_tx_ready) begin
                    next_state_s = ST_WAIT_DONE;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_WAIT_DONE: begin
                if (i_tx_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM state and registered transmit strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= ST_IDLE;
            tx_valid_r <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            tx_valid_r <= (next_state_s == ST_SEND);
        end
    end

    // Count of complete lines held in the FIFO.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            line_cnt_r <= {LW{1'b0}};
        end else if (flush_clr_s) begin
            line_cnt_r <= {LW{1'b0}};
        end else if (line_inc_s && !line_dec_s) begin
            line_cnt_r <= line_cnt_r + LW'(1);
        end else if (line_dec_s && !line_inc_s) begin
            line_cnt_r <= line_cnt_r - LW'(1);
        end
    end

    // Drop statistics; clearing wins over a coincident drop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= 8'd0;
        end else if (i_clr_stat) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= 8'd0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            drop_cnt_r <= sat_inc8(drop_cnt_r);
        end
    end

    assign o_tx_data  = rd_data_s;
    assign o_tx_valid = tx_valid_r;
    assign o_level    = level_s;
    assign o_full     = full_s;
    assign o_empty    = empty_s;
    assign o_rts_n    = afull_s;
    assign o_overflow = overflow_r;
    assign o_drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_uart_loopback_buffer.sv
// Self-checking bench for uart_loopback_buffer (depth 4, almost-full 3) with a
// transmitter model and a queue-based reference for randomized traffic.
module tb_uart_loopback_buffer;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [1:0] mode;
    logic       clr_stat;
    logic [2:0] level;
    logic       full;
    logic       empty;
    logic       rts_n;
    logic       overflow;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] sent_q [$];
    int valid_pulses = 0;

    always #5 clk = ~clk;

    uart_loopback_buffer #(
        .P_DATA_WIDTH (8),
        .P_DEPTH      (4),
        .P_AFULL      (3),
        .P_EOL        (8'h0A)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .i_mode     (mode),
        .i_clr_stat (clr_stat),
        .o_level    (level),
        .o_full     (full),
        .o_empty    (empty),
        .o_rts_n    (rts_n),
        .o_overflow (overflow),
        .o_drop_cnt (drop_cnt)
    );

    // Transmitter model: records each strobe and goes busy for two cycles.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_valid === 1'b1) begin
                sent_q.push_back(tx_data);
                valid_pulses++;
                tx_ready = 1'b0;
                repeat (2) @(negedge clk);
                tx_ready = 1'b1;
            end
        end
    end

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_sent(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sent_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (sent_q.size() >= n) ok = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic cleanup();
        @(negedge clk);
        mode = MODE_FLUSH;
        repeat (12) @(negedge clk);
        mode     = MODE_PAUSE;
        clr_stat = 1'b1;
        @(negedge clk);
        clr_stat = 1'b0;
        @(negedge clk);
        sent_q.delete();
        valid_pulses = 0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        mode     = MODE_PAUSE;
        clr_stat = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_valid, tx_data, level, empty, full, rts_n, overflow, drop_cnt} !==
            {1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_values got %h", {tx_valid, tx_data, level, empty, full, rts_n, overflow, drop_cnt});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stream();
        mode = MODE_STREAM;
        write_byte(8'h55);
        checks++;
        if (tx_valid !== 1'b0 || level !== 3'd1) begin
            errors++;
            $display("FAIL stream_n1 got valid=%b level=%0d expected 0/1", tx_valid, level);
        end
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_n2 got valid=%b expected 0", tx_valid);
        end
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h55) begin
            errors++;
            $display("FAIL stream_n3 got valid=%b data=%h expected 1/55", tx_valid, tx_data);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (empty !== 1'b1 || valid_pulses !== 1) begin
            errors++;
            $display("FAIL stream_done got empty=%b pulses=%0d expected 1/1", empty, valid_pulses);
        end
        cleanup();
    endtask

    task automatic test_line();
        bit ok;
        mode = MODE_LINE;
        write_byte(8'h41);
        write_byte(8'h42);
        repeat (6) @(negedge clk);
        checks++;
        if (valid_pulses !== 0 || level !== 3'd2) begin
            errors++;
            $display("FAIL line_hold got pulses=%0d level=%0d expected 0/2", valid_pulses, level);
        end
        write_byte(8'h0A);
        wait_sent(3, 60, ok);
        checks++;
        if (!ok || {sent_q[0], sent_q[1], sent_q[2]} !== 24'h41420A) begin
            errors++;
            $display("FAIL line_send got ok=%b count=%0d expected 41420a", ok, sent_q.size());
        end
        repeat (4) @(negedge clk);
        write_byte(8'h43);
        repeat (12) @(negedge clk);
        checks++;
        if (valid_pulses !== 3 || level !== 3'd1) begin
            errors++;
            $display("FAIL line_cnt_zero got pulses=%0d level=%0d expected 3/1", valid_pulses, level);
        end
        cleanup();
    endtask

    task automatic test_overflow();
        mode = MODE_PAUSE;
        for (int i = 0; i < 6; i++) begin
            write_byte(8'($urandom));
            if (i == 1) begin
                checks++;
                if (rts_n !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_rts_low got %b expected 0", rts_n);
                end
            end
            if (i == 2) begin
                checks++;
                if (rts_n !== 1'b1 || full !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_rts_high got rts=%b full=%b expected 1/0", rts_n, full);
                end
            end
            if (i == 3) begin
                checks++;
                if (full !== 1'b1 || drop_cnt !== 8'd0) begin
                    errors++;
                    $display("FAIL ovf_full got full=%b drops=%0d expected 1/0", full, drop_cnt);
                end
            end
        end
        checks++;
        if (drop_cnt !== 8'd2 || overflow !== 1'b1 || level !== 3'd4) begin
            errors++;
            $display("FAIL ovf_stats got drops=%0d ovf=%b level=%0d expected 2/1/4", drop_cnt, overflow, level);
        end
        @(negedge clk);
        clr_stat = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        @(negedge clk);
        clr_stat = 1'b0;
        rx_valid = 1'b0;
        checks++;
        if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got drops=%0d ovf=%b expected 0/0", drop_cnt, overflow);
        end
        cleanup();
    endtask

    task automatic test_flush();
        mode = MODE_PAUSE;
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        checks++;
        if (level !== 3'd3) begin
            errors++;
            $display("FAIL flush_pre got level=%0d expected 3", level);
        end
        mode     = MODE_FLUSH;
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        repeat (2) @(negedge clk);
        mode     = MODE_PAUSE;
        rx_valid = 1'b0;
        checks++;
        if (level !== 3'd0 || empty !== 1'b1 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear got level=%0d empty=%b drops=%0d ovf=%b expected 0/1/0/0",
                     level, empty, drop_cnt, overflow);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (level !== 3'd0 || valid_pulses !== 0) begin
            errors++;
            $display("FAIL flush_after got level=%0d pulses=%0d expected 0/0", level, valid_pulses);
        end
        cleanup();
    endtask

    task automatic test_mid_send_pause();
        bit ok;
        logic [7:0] b0, b1;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        mode = MODE_PAUSE;
        write_byte(b0);
        write_byte(b1);
        mode = MODE_STREAM;
        wait_valid(20, ok);
        @(negedge clk);
        mode = MODE_PAUSE;
        repeat (15) @(negedge clk);
        checks++;
        if (!ok || valid_pulses !== 1 || level !== 3'd1 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL pause_mid got ok=%b pulses=%0d level=%0d expected 1/1/1", ok, valid_pulses, level);
        end
        mode = MODE_STREAM;
        wait_sent(2, 30, ok);
        checks++;
        if (!ok || {sent_q[0], sent_q[1]} !== {b0, b1}) begin
            errors++;
            $display("FAIL pause_resume got ok=%b count=%0d expected %h%h", ok, sent_q.size(), b0, b1);
        end
        cleanup();
    endtask

    task automatic test_reset_mid();
        bit ok;
        mode = MODE_PAUSE;
        write_byte(8'hA5);
        write_byte(8'h5A);
        mode = MODE_STREAM;
        wait_valid(20, ok);
        rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || {tx_valid, tx_data, level, empty, full, rts_n, overflow, drop_cnt} !==
            {1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_mid got ok=%b outs=%h", ok, {tx_valid, tx_data, level, empty, full, rts_n, overflow, drop_cnt});
        end
        @(negedge clk);
        mode  = MODE_PAUSE;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (empty !== 1'b1 || level !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_after got empty=%b level=%0d expected 1/0", empty, level);
        end
        cleanup();
    endtask

    task automatic test_random();
        logic [7:0] mq [$];
        logic [7:0] exp_q [$];
        logic [7:0] b;
        int mdrop;
        int k;
        int last_eol;
        bit ok;
        mdrop = 0;
        for (int r = 0; r < 6; r++) begin
            mq.delete();
            mode = MODE_PAUSE;
            k = $urandom_range(0, 6);
            for (int j = 0; j < k; j++) begin
                b = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
                write_byte(b);
                if (mq.size() < 4) mq.push_back(b);
                else mdrop++;
                checks++;
                if (level !== 3'(mq.size()) || full !== (mq.size() == 4) || rts_n !== (mq.size() >= 3) ||
                    drop_cnt !== 8'(mdrop) || overflow !== (mdrop > 0)) begin
                    errors++;
                    $display("FAIL rand_fill got level=%0d full=%b rts=%b drops=%0d ovf=%b expected level=%0d drops=%0d",
                             level, full, rts_n, drop_cnt, overflow, mq.size(), mdrop);
                end
            end
            mode = MODE_STREAM;
            wait_sent(mq.size(), 20 + 10 * mq.size(), ok);
            repeat (6) @(negedge clk);
            checks++;
            if (!ok || sent_q.size() !== mq.size() || empty !== 1'b1) begin
                errors++;
                $display("FAIL rand_stream_count got %0d empty=%b expected %0d", sent_q.size(), empty, mq.size());
            end else begin
                for (int j = 0; j < mq.size(); j++) begin
                    checks++;
                    if (sent_q[j] !== mq[j]) begin
                        errors++;
                        $display("FAIL rand_stream_data[%0d] got %h expected %h", j, sent_q[j], mq[j]);
                    end
                end
            end
            sent_q.delete();
            valid_pulses = 0;
        end
        for (int r = 0; r < 4; r++) begin
            mq.delete();
            exp_q.delete();
            mode = MODE_PAUSE;
            k = $urandom_range(1, 3);
            last_eol = -1;
            for (int j = 0; j < k; j++) begin
                b = ($urandom_range(0, 2) == 0) ? 8'h0A : (8'h20 + 8'($urandom_range(0, 90)));
                write_byte(b);
                mq.push_back(b);
                if (b == 8'h0A) last_eol = j;
            end
            for (int j = 0; j <= last_eol; j++) exp_q.push_back(mq[j]);
            mode = MODE_LINE;
            wait_sent(exp_q.size(), 20 + 10 * k, ok);
            repeat (15) @(negedge clk);
            checks++;
            if (!ok || valid_pulses !== exp_q.size() || level !== 3'(k - exp_q.size())) begin
                errors++;
                $display("FAIL rand_line got pulses=%0d level=%0d expected %0d/%0d",
                         valid_pulses, level, exp_q.size(), k - exp_q.size());
            end else begin
                for (int j = 0; j < exp_q.size(); j++) begin
                    checks++;
                    if (sent_q[j] !== exp_q[j]) begin
                        errors++;
                        $display("FAIL rand_line_data[%0d] got %h expected %h", j, sent_q[j], exp_q[j]);
                    end
                end
            end
            cleanup();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_line();
        test_overflow();
        test_flush();
        test_mid_send_pause();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_loopback_buffer.md
# uart_loopback_buffer

Parametrised receive-to-transmit buffer placed between the receive and transmit user ports of `uart_drive`. It replaces the ad-hoc FIFO and read-pulse logic used in loopback tops with one self-contained block. It provides:
- configurable data width and depth;
- stream, line, pause and flush modes;
- RTS-style flow control;
- fill-level reporting and overflow statistics.

## Interface
Parameters:
- `P_DATA_WIDTH`, 8: byte width; matches `P_UART_DATA_WIDTH`.
- `P_DEPTH`, 64: FIFO entries; power of two, at least 4.
- `P_AFULL`, 48: level at or above which `o_rts_n` deasserts (goes high); 1 ≤ `P_AFULL` ≤ `P_DEPTH`.
- `P_EOL`, 8'h0A: line terminator used in line mode.

Ports (`LW` = $clog2(`P_DEPTH`)+1):
- `i_clk`, in, 1: sole clock, normally `o_user_clk` of `uart_drive`.
- `i_rst_n`, in, 1: asynchronous active-low reset.
- `i_rx_data`, in, `P_DATA_WIDTH`: received byte.
- `i_rx_valid`, in, 1: one-cycle strobe marking `i_rx_data` valid.
- `o_tx_data`, out, `P_DATA_WIDTH`: byte to transmit; held stable from the `o_tx_valid` pulse until the next pop.
- `o_tx_valid`, out, 1: one-cycle transmit strobe.
- `i_tx_ready`, in, 1: transmitter idle.
- `i_mode`, in, 2: 0 stream, 1 line, 2 pause, 3 flush.
- `i_clr_stat`, in, 1: clears `o_overflow` and `o_drop_cnt`.
- `o_level`, out, `LW`: current FIFO occupancy.
- `o_full`, out, 1: FIFO full.
- `o_empty`, out, 1: FIFO empty.
- `o_rts_n`, out, 1: 0 while `o_level` < `P_AFULL` (remote may send).
- `o_overflow`, out, 1: sticky; set by any dropped write.
- `o_drop_cnt`, out, 8: count of dropped writes, saturating at 255.

## Operation
Reset values:
- `o_tx_valid`=0, `o_tx_data`=0
- `o_level`=0, `o_empty`=1, `o_full`=0
- `o_rts_n`=0
- `o_overflow`=0, `o_drop_cnt`=0
- FSM in IDLE; line counter 0

Write path:
- A write occurs on `i_rx_valid` when FIFO is not full and `i_mode`≠3.
- A write while full is dropped: `o_overflow` sets and `o_drop_cnt` increments, saturating.
- A write during flush is dropped silently; statistics are not affected.
- Full status is evaluated before any pop in the same cycle. A write in the same cycle as a pop on a full FIFO is therefore still dropped.

Line counter:
- Increments on each accepted byte equal to `P_EOL`.
- Decrements on each popped byte equal to `P_EOL`.
- Simultaneous increment and decrement leaves it unchanged.

Send permission (`go`), by mode:
- Stream: !`o_empty`.
- Line: !`o_empty` and (line counter > 0 or `o_full`).
- Pause: never.
- Flush: never.

FSM:
- IDLE → POP when `go` and `i_tx_ready`. In flush mode, IDLE resets the pointers and the line counter each cycle.
- POP: FIFO read enable high for exactly one cycle → SEND.
- SEND: `o_tx_valid`=1 for one cycle with the popped data → WAIT_BUSY.
- WAIT_BUSY: wait for `i_tx_ready`=0 → WAIT_DONE.
- WAIT_DONE: wait for `i_tx_ready`=1 → IDLE.

Mode changes:
- A mode change never aborts a byte already in POP, SEND or the wait states.
- Flush takes effect only once the FSM reaches IDLE.

Statistics:
- `i_clr_stat` has priority over a coincident drop; both statistics clear.

## Timing
- Reset is asynchronous on assertion. Deassertion is expected synchronised externally.
- `o_level`, `o_empty`, `o_full` and `o_rts_n` are registered and update the cycle after the write or pop.
- FIFO read data is registered, with one cycle of latency from read enable.
- Latency with empty FIFO, stream mode and `i_tx_ready`=1:
  - `i_rx_valid` in cycle n;
  - POP in cycle n+2;
  - `o_tx_valid` in cycle n+3.
- Minimum gap between `o_tx_valid` pulses is 5 cycles, given a transmitter that drops ready one cycle after valid.

## Structure
- Shared package `uart_pkg` holds:
  - mode encodings `MODE_STREAM`, `MODE_LINE`, `MODE_PAUSE`, `MODE_FLUSH`;
  - the FSM state enum.
- Sub-module `sync_fifo`, instantiated once, provides:
  - parametrised width and depth;
  - registered read data;
  - level, full and empty outputs;
  - synchronous clear input (used by flush).
- Flow control, line counter, statistics and FSM live in the top of this block.

## Test plan
- Stream: write 8'h55, ready=1 → `o_tx_valid` pulse at n+3 with `o_tx_data`=8'h55. After the transmitter model cycles ready, `o_empty`=1.
- Line mode: write "AB" then 8'h0A → nothing sent until 8'h0A is accepted. Then 8'h41, 8'h42, 8'h0A are sent in order and the line counter returns to 0.
- Overflow: `P_DEPTH`=4, `P_AFULL`=3, pause mode, 6 writes:
  - `o_rts_n`=1 after the third write;
  - `o_full`=1 after the fourth write;
  - `o_drop_cnt`=2, `o_overflow`=1;
  - `i_clr_stat` → both 0.
- Flush: 3 bytes queued in pause mode, switch to flush for 2 cycles → `o_level`=0, no `o_tx_valid`. Writes during flush are not counted.
- Mid-send mode change: switch to pause during WAIT_BUSY → that byte completes and no further pop occurs until stream mode returns.
- Reset mid-operation: `i_rst_n`=0 in SEND → all outputs return to reset values immediately and the FIFO is empty afterwards.
